// File: rtl/uart_byte_rx_if.sv
// Write-side bundle from uart_byte_rx into the byte buffer.
// wr_en/wr_data map onto wea/dina; frame_err and busy are status.
interface uart_byte_rx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       frame_err;
    logic       busy;

    modport master (
        output wr_en,
        output wr_data,
        output frame_err,
        output busy
    );

    modport slave (
        input wr_en,
        input wr_data,
        input frame_err,
        input busy
    );
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver feeding the byte buffer write port.
// Ports: clk, rst (sync, active-high), rx (async line, idle high),
//   wr (master): wr_en 1-cycle strobe, wr_data last good byte,
//   frame_err 1-cycle bad-stop pulse, busy high outside IDLE.
module uart_byte_rx #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    uart_byte_rx_if.master wr
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_byte_rx: CLKS_PER_BIT must be >= 4");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Sync flops preset high so reset looks like an idle line.
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            state        <= IDLE;
            clk_cnt      <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            wr.wr_en     <= 1'b0;
            wr.wr_data   <= 8'h00;
            wr.frame_err <= 1'b0;
            wr.busy      <= 1'b0;
        end else begin
            rx_meta      <= rx;
            rx_s         <= rx_meta;
            wr.wr_en     <= 1'b0;
            wr.frame_err <= 1'b0;

            unique case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_s) begin
                        state   <= START;
                        wr.busy <= 1'b1;
                    end
                end

                START: begin
                    if (clk_cnt == HALF_END) begin
                        clk_cnt <= '0;
                        // Still low at mid-start: real start bit.
                        // High again: a glitch, drop back quietly.
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state   <= IDLE;
                            wr.busy <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (clk_cnt == BIT_END) begin
                        clk_cnt        <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                STOP: begin
                    // Decide at mid-stop-bit and leave at once so an
                    // immediately following start edge is still seen.
                    if (clk_cnt == BIT_END) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            wr.wr_en   <= 1'b1;
                            wr.wr_data <= shreg;
                            state      <= IDLE;
                            wr.busy    <= 1'b0;
                        end else begin
                            wr.frame_err <= 1'b1;
                            state        <= BREAK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                BREAK: begin
                    // Hold off until the line is released so a stuck-low
                    // line does not keep retriggering START.
                    clk_cnt <= '0;
                    if (rx_s) begin
                        state   <= IDLE;
                        wr.busy <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    clk_cnt <= '0;
                    wr.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx with CLKS_PER_BIT = 16.
// Stimulus pushes expected events; a monitor pops on each output pulse.
module tb_uart_byte_rx;

    localparam int CPB = 16;

    logic clk;
    logic rst;
    logic rx;

    uart_byte_rx_if wr_if ();

    uart_byte_rx #(
        .CLK_HZ      (1_600_000),
        .BAUD        (100_000),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx (rx),
        .wr (wr_if)
    );

    typedef struct {
        bit         ferr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   wr_times[$];
    int   compared;
    int   mismatched;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every wr_en / frame_err pulse must match the queue head.
    always @(negedge clk) begin
        if (wr_if.wr_en || wr_if.frame_err) begin
            compared = compared + 1;
            if (wr_if.wr_en && wr_if.frame_err) begin
                mismatched = mismatched + 1;
                $display("FAIL both_flags: wr_en=1 frame_err=1 at cycle %0d, required exclusive", cyc);
            end else if (exp_q.size() == 0) begin
                mismatched = mismatched + 1;
                $display("FAIL unexpected_event: wr_en=%0b frame_err=%0b data=%02h at cycle %0d, required none",
                         wr_if.wr_en, wr_if.frame_err, wr_if.wr_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.ferr != wr_if.frame_err || e.data != wr_if.wr_data) begin
                    mismatched = mismatched + 1;
                    $display("FAIL event: got frame_err=%0b data=%02h, required frame_err=%0b data=%02h",
                             wr_if.frame_err, wr_if.wr_data, e.ferr, e.data);
                end
            end
            if (wr_if.wr_en) wr_times.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        compared = compared + 1;
        if (got !== req) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic expect_wr(input logic [7:0] d);
        exp_t e;
        e.ferr = 1'b0;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_ferr(input logic [7:0] held);
        exp_t e;
        e.ferr = 1'b1;
        e.data = held;
        exp_q.push_back(e);
    endtask

    // Called on a negedge; returns on a negedge with the stop bit done.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int per);
        rx = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (per) @(negedge clk);
        end
        rx = stop_bit;
        repeat (per) @(negedge clk);
        rx = 1'b1;
    endtask

    // Bit period in time units, off the clock grid to skew the phase.
    task automatic send_frame_t(input logic [7:0] b, input int per_t);
        #2;
        rx = 1'b0;
        #(per_t);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(per_t);
        end
        rx = 1'b1;
        #(per_t);
        @(negedge clk);
    endtask

    task automatic drain(input string name, input int limit);
        for (int i = 0; i < limit && exp_q.size() > 0; i++) @(negedge clk);
        compared = compared + 1;
        if (exp_q.size() != 0) begin
            mismatched = mismatched + 1;
            $display("FAIL %s_timeout: %0d events pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        rx         = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_wr_en", 32'(wr_if.wr_en), 32'd0);
        check("reset_wr_data", 32'(wr_if.wr_data), 32'h00);
        check("reset_frame_err", 32'(wr_if.frame_err), 32'd0);
        check("reset_busy", 32'(wr_if.busy), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single byte
        expect_wr(8'hA5);
        send_frame(8'hA5, 1'b1, CPB);
        drain("t1", 400);
        repeat (4) @(negedge clk);
        check("t1_busy_after", 32'(wr_if.busy), 32'd0);
        check("t1_data_held", 32'(wr_if.wr_data), 32'hA5);

        // 2: back-to-back, no idle gap
        repeat (10) @(negedge clk);
        wr_times.delete();
        expect_wr(8'h00);
        expect_wr(8'hFF);
        expect_wr(8'h3C);
        send_frame(8'h00, 1'b1, CPB);
        send_frame(8'hFF, 1'b1, CPB);
        send_frame(8'h3C, 1'b1, CPB);
        drain("t2", 400);
        check("t2_pulse_count", 32'(wr_times.size()), 32'd3);
        if (wr_times.size() == 3) begin
            check("t2_spacing_a", 32'(wr_times[1] - wr_times[0]), 32'd160);
            check("t2_spacing_b", 32'(wr_times[2] - wr_times[1]), 32'd160);
        end

        // 3: 4-cycle glitch, then a real frame
        repeat (10) @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("t3_busy_after_glitch", 32'(wr_if.busy), 32'd0);
        expect_wr(8'h5A);
        send_frame(8'h5A, 1'b1, CPB);
        drain("t3", 400);

        // 4: bad stop bit, line held low, then recovery
        repeat (10) @(negedge clk);
        expect_ferr(8'h5A);
        send_frame(8'h81, 1'b0, CPB);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        drain("t4_ferr", 10);
        check("t4_busy_in_break", 32'(wr_if.busy), 32'd1);
        check("t4_data_kept", 32'(wr_if.wr_data), 32'h5A);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("t4_busy_released", 32'(wr_if.busy), 32'd0);
        expect_wr(8'h42);
        send_frame(8'h42, 1'b1, CPB);
        drain("t4", 400);

        // 5: reset during bit 4 of 0xC3
        repeat (10) @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0 || i == 1) ? 1'b1 : 1'b0;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        check("t5_busy_before_rst", 32'(wr_if.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_wr_en", 32'(wr_if.wr_en), 32'd0);
        check("t5_rst_wr_data", 32'(wr_if.wr_data), 32'h00);
        check("t5_rst_frame_err", 32'(wr_if.frame_err), 32'd0);
        check("t5_rst_busy", 32'(wr_if.busy), 32'd0);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (200) @(negedge clk);
        expect_wr(8'h99);
        send_frame(8'h99, 1'b1, CPB);
        drain("t5", 400);
        check("t5_data", 32'(wr_if.wr_data), 32'h99);

        // 6: baud skew, bit period 15.5 and 16.5 clocks
        repeat (10) @(negedge clk);
        expect_wr(8'h6E);
        send_frame_t(8'h6E, 155);
        drain("t6_fast", 400);
        repeat (10) @(negedge clk);
        expect_wr(8'h6E);
        send_frame_t(8'h6E, 165);
        drain("t6_slow", 400);

        repeat (20) @(negedge clk);
        check("final_busy", 32'(wr_if.busy), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
